// File: rtl/div_share_ctrl_if.sv
// div_share_ctrl_if
//   Bundles every non-clock signal of the divider-sharing controller:
//   the NREQ requester channels (valid/ready plus packed operands), the
//   single tagged response channel, and the start/busy/valid/dbz link to
//   the shared iterative divider.
//   Modports:
//     slave  - used by div_share_ctrl (consumes requests, drives divider)
//     master - used by the environment (requesters, response sink, divider)
interface div_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
);
  // requester side
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  // response side
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_q;
  logic [WIDTH-1:0]      rsp_r;
  logic                  rsp_dbz;
  logic                  rsp_err;
  // divider side
  logic                  div_start;
  logic [WIDTH-1:0]      div_x;
  logic [WIDTH-1:0]      div_y;
  logic                  div_busy;
  logic                  div_valid;
  logic                  div_dbz;
  logic [WIDTH-1:0]      div_q;
  logic [WIDTH-1:0]      div_r;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    input  div_busy, div_valid, div_dbz, div_q, div_r,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
    output div_start, div_x, div_y
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    output div_busy, div_valid, div_dbz, div_q, div_r,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_err,
    input  div_start, div_x, div_y
  );
endinterface

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares one iterative WIDTH-bit divider among NREQ requesters.
//   A round-robin arbiter picks one requester while the controller is idle
//   and the divider is not busy, latches its operands, pulses div_start,
//   then follows either the divider's early-out path (busy never rises) or
//   its iterative path (valid after the busy phase). The tagged result is
//   held on the response channel until accepted. A watchdog aborts the
//   wait if the divider never finishes and reports rsp_err.
//   Ports:
//     clk   - clock, all state changes on the rising edge
//     rst_n - asynchronous active-low reset
//     bus   - div_share_ctrl_if.slave: requester, response and divider links
module div_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = WIDTH + 8
) (
  input  logic            clk,
  input  logic            rst_n,
  div_share_ctrl_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, CHECK, WAIT, RESP} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg,   ptr_next;
  logic [IDW-1:0]   id_reg,    id_next;
  logic [WDW-1:0]   wd_reg,    wd_next;
  logic [WIDTH-1:0] x_reg,     x_next;
  logic [WIDTH-1:0] y_reg,     y_next;
  logic [WIDTH-1:0] q_reg,     q_next;
  logic [WIDTH-1:0] r_reg,     r_next;
  logic             dbz_reg,   dbz_next;
  logic             err_reg,   err_next;

  // Unpack the flat operand buses into per-requester words.
  logic [WIDTH-1:0] op_x [NREQ];
  logic [WIDTH-1:0] op_y [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_x[gi] = bus.req_x[gi*WIDTH +: WIDTH];
      assign op_y[gi] = bus.req_y[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search: first valid requester at or above ptr_reg,
  // wrapping at NREQ-1. cand is one bit wider so the wrap also works
  // when NREQ is not a power of two.
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_reg;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_reg} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // A grant is only possible from IDLE with the divider quiet; this also
  // covers a reset that arrived while a division was still running.
  logic grant_fire;
  assign grant_fire = (state_reg == IDLE) && !bus.div_busy && grant_found;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    wd_next    = wd_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dbz_next   = dbz_reg;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (grant_fire) begin
          x_next     = op_x[grant_idx];
          y_next     = op_y[grant_idx];
          id_next    = grant_idx;
          ptr_next   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        state_next = CHECK;
      end

      // The divider's outputs now reflect the start edge: busy low means
      // it took an early-out and the result is already on div_q/div_r.
      CHECK: begin
        if (!bus.div_busy) begin
          q_next     = bus.div_q;
          r_next     = bus.div_r;
          dbz_next   = bus.div_dbz;
          err_next   = 1'b0;
          state_next = RESP;
        end else begin
          wd_next    = '0;
          state_next = WAIT;
        end
      end

      // A completed result wins over a watchdog expiry in the same cycle.
      WAIT: begin
        wd_next = wd_reg + 1'b1;
        if (bus.div_valid && !bus.div_busy) begin
          q_next     = bus.div_q;
          r_next     = bus.div_r;
          dbz_next   = 1'b0;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (wd_reg == WDW'(TIMEOUT-1)) begin
          q_next     = '0;
          r_next     = '0;
          dbz_next   = 1'b0;
          err_next   = 1'b1;
          state_next = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      wd_reg    <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dbz_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      wd_reg    <= wd_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dbz_reg   <= dbz_next;
      err_reg   <= err_next;
    end
  end

  assign bus.req_ready = grant_fire ? (NREQ'(1) << grant_idx) : '0;
  assign bus.div_start = (state_reg == ISSUE);
  assign bus.div_x     = x_reg;
  assign bus.div_y     = y_reg;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_q     = q_reg;
  assign bus.rsp_r     = r_reg;
  assign bus.rsp_dbz   = dbz_reg;
  assign bus.rsp_err   = err_reg;

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;
  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = WIDTH + 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_share_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus();

  div_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp     = 0;
  int n_err     = 0;
  int start_cnt = 0;

  // Behavioural divider: early-out for y==0, x==0, x<y (no valid pulse);
  // otherwise busy for WIDTH+1 cycles, then valid (level) until next start.
  // hang keeps it busy indefinitely. It has no reset.
  logic             m_busy  = 1'b0;
  logic             m_valid = 1'b0;
  logic             m_dbz   = 1'b0;
  logic [WIDTH-1:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;
  int               m_cnt = 0;
  logic             hang  = 1'b0;

  assign bus.div_busy  = m_busy;
  assign bus.div_valid = m_valid;
  assign bus.div_dbz   = m_dbz;
  assign bus.div_q     = m_q;
  assign bus.div_r     = m_r;

  always @(posedge clk) begin
    if (bus.div_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      m_valid   <= 1'b0;
      if (bus.div_y == '0) begin
        m_dbz <= 1'b1; m_q <= '0; m_r <= '0; m_busy <= 1'b0;
      end else if (bus.div_x == '0 || bus.div_x < bus.div_y) begin
        m_dbz <= 1'b0; m_q <= '0; m_r <= bus.div_x; m_busy <= 1'b0;
      end else begin
        m_dbz <= 1'b0; m_busy <= 1'b1; m_cnt <= WIDTH;
        m_a <= bus.div_x; m_b <= bus.div_y;
      end
    end else if (m_busy) begin
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
      else if (!hang) begin
        m_busy <= 1'b0; m_valid <= 1'b1; m_q <= m_a / m_b; m_r <= m_a % m_b;
      end
    end
  end

  task automatic set_op(input int k, input int x, input int y);
    bus.req_x[k*WIDTH +: WIDTH] = WIDTH'(x);
    bus.req_y[k*WIDTH +: WIDTH] = WIDTH'(y);
  endtask

  // Raise req_valid[k] and wait for its grant; returns the observed
  // req_ready vector and leaves time just after the grant edge.
  task automatic issue(input int k, input int x, input int y,
                       output logic [NREQ-1:0] rdy, output bit ok);
    ok  = 1'b0;
    rdy = '0;
    @(negedge clk);
    set_op(k, x, y);
    bus.req_valid = NREQ'(1) << k;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (bus.req_ready !== '0) begin
        rdy = bus.req_ready;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  // Counts falling edges until rsp_valid; prints the transaction.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      lat++;
      if (bus.rsp_valid === 1'b1) break;
    end
    $display("txn id=%0d q=%0d r=%0d dbz=%0b err=%0b lat=%0d",
             bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.rsp_dbz, bus.rsp_err, lat);
  endtask

  task automatic accept();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_dbz, bus.rsp_err, bus.div_start} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000",
                        {bus.rsp_valid, bus.rsp_dbz, bus.rsp_err, bus.div_start});
    end
    n_cmp++;
    if ({bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.div_x, bus.div_y} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0",
                        {bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.div_x, bus.div_y});
    end
    n_cmp++;
    if (bus.req_ready !== 4'b0000) begin
      n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy; bit ok; int lat; int s0;
    s0 = start_cnt;
    issue(1, 100, 7, rdy, ok);
    n_cmp++;
    if (!ok || rdy !== 4'b0010) begin
      n_err++; $display("FAIL single_grant: got %b want 0010", rdy);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat != WIDTH + 4) begin
      n_err++; $display("FAIL single_latency: got %0d want %0d", lat, WIDTH + 4);
    end
    n_cmp++;
    if (bus.rsp_id !== 2'd1) begin
      n_err++; $display("FAIL single_id: got %0d want 1", bus.rsp_id);
    end
    n_cmp++;
    if (bus.rsp_q !== WIDTH'(14) || bus.rsp_r !== WIDTH'(2)) begin
      n_err++; $display("FAIL single_qr: got %0d/%0d want 14/2", bus.rsp_q, bus.rsp_r);
    end
    n_cmp++;
    if ({bus.rsp_dbz, bus.rsp_err} !== 2'b00) begin
      n_err++; $display("FAIL single_flags: got %b want 00", {bus.rsp_dbz, bus.rsp_err});
    end
    n_cmp++;
    if (start_cnt - s0 != 1) begin
      n_err++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0);
    end
    accept();
    n_cmp++;
    if (bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL single_release: got %b want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_early_out();
    logic [NREQ-1:0] rdy; bit ok; int lat;
    issue(0, 5, 0, rdy, ok);
    n_cmp++;
    if (!ok || rdy !== 4'b0001) begin
      n_err++; $display("FAIL dbz_grant: got %b want 0001", rdy);
    end
    wait_rsp(lat);
    n_cmp++;
    if (lat != 3) begin
      n_err++; $display("FAIL dbz_latency: got %0d want 3", lat);
    end
    n_cmp++;
    if ({bus.rsp_dbz, bus.rsp_err, bus.rsp_q, bus.rsp_r} !== {2'b10, WIDTH'(0), WIDTH'(0)}) begin
      n_err++; $display("FAIL dbz_result: got dbz=%b err=%b q=%0d r=%0d want dbz=1 err=0 q=0 r=0",
                        bus.rsp_dbz, bus.rsp_err, bus.rsp_q, bus.rsp_r);
    end
    accept();
    issue(0, 3, 9, rdy, ok);
    wait_rsp(lat);
    n_cmp++;
    if (lat != 3) begin
      n_err++; $display("FAIL small_latency: got %0d want 3", lat);
    end
    n_cmp++;
    if ({bus.rsp_dbz, bus.rsp_q, bus.rsp_r} !== {1'b0, WIDTH'(0), WIDTH'(3)}) begin
      n_err++; $display("FAIL small_result: got dbz=%b q=%0d r=%0d want dbz=0 q=0 r=3",
                        bus.rsp_dbz, bus.rsp_q, bus.rsp_r);
    end
    accept();
  endtask

  task automatic test_round_robin();
    int lat; int s0;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int exp_q  [4] = '{10, 22, 2, 0};
    int exp_r  [4] = '{0, 2, 1, 4};
    // restart the pointer at 0 while the divider is idle
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    set_op(0, 50, 5); set_op(1, 200, 9); set_op(2, 7, 3); set_op(3, 4, 9);
    s0 = start_cnt;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(lat);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1) begin
        n_err++; $display("FAIL rr_timeout op%0d: got no response want response", i);
      end
      n_cmp++;
      if (bus.rsp_id !== IDW'(exp_id[i])) begin
        n_err++; $display("FAIL rr_id op%0d: got %0d want %0d", i, bus.rsp_id, exp_id[i]);
      end
      n_cmp++;
      if (bus.rsp_q !== WIDTH'(exp_q[exp_id[i]]) || bus.rsp_r !== WIDTH'(exp_r[exp_id[i]])) begin
        n_err++; $display("FAIL rr_qr op%0d: got %0d/%0d want %0d/%0d", i, bus.rsp_q,
                          bus.rsp_r, exp_q[exp_id[i]], exp_r[exp_id[i]]);
      end
      n_cmp++;
      if (start_cnt - s0 != i + 1) begin
        n_err++; $display("FAIL rr_starts op%0d: got %0d want %0d", i, start_cnt - s0, i + 1);
      end
    end
    bus.req_valid = '0;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] rdy; bit ok; int lat;
    issue(2, 60, 7, rdy, ok);
    n_cmp++;
    if (!ok || rdy !== 4'b0100) begin
      n_err++; $display("FAIL bp_grant: got %b want 0100", rdy);
    end
    set_op(3, 9, 3);
    bus.req_valid = 4'b1000;
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.rsp_dbz, bus.rsp_err, bus.req_ready}
          !== {1'b1, 2'd2, WIDTH'(8), WIDTH'(4), 2'b00, 4'b0000}) begin
        n_err++; $display("FAIL bp_hold cyc%0d: got v=%b id=%0d q=%0d r=%0d rdy=%b want v=1 id=2 q=8 r=4 rdy=0000",
                          i, bus.rsp_valid, bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.req_ready);
      end
      @(negedge clk); #1;
    end
    accept();
    n_cmp++;
    if ({bus.rsp_valid, bus.req_ready} !== {1'b0, 4'b1000}) begin
      n_err++; $display("FAIL bp_after: got v=%b rdy=%b want v=0 rdy=1000",
                        bus.rsp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    n_cmp++;
    if (bus.rsp_id !== 2'd3 || bus.rsp_q !== WIDTH'(3) || bus.rsp_r !== WIDTH'(0)) begin
      n_err++; $display("FAIL bp_next: got id=%0d q=%0d r=%0d want id=3 q=3 r=0",
                        bus.rsp_id, bus.rsp_q, bus.rsp_r);
    end
    accept();
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] rdy; bit ok; int lat;
    hang = 1'b1;
    issue(1, 100, 3, rdy, ok);
    wait_rsp(lat);
    n_cmp++;
    if (lat != TIMEOUT + 3) begin
      n_err++; $display("FAIL to_latency: got %0d want %0d", lat, TIMEOUT + 3);
    end
    n_cmp++;
    if ({bus.rsp_err, bus.rsp_dbz, bus.rsp_q, bus.rsp_r, bus.rsp_id}
        !== {2'b10, WIDTH'(0), WIDTH'(0), 2'd1}) begin
      n_err++; $display("FAIL to_result: got err=%b dbz=%b q=%0d r=%0d id=%0d want err=1 dbz=0 q=0 r=0 id=1",
                        bus.rsp_err, bus.rsp_dbz, bus.rsp_q, bus.rsp_r, bus.rsp_id);
    end
    accept();
    n_cmp++;
    if (bus.rsp_err !== 1'b0) begin
      n_err++; $display("FAIL to_err_clear: got %b want 0", bus.rsp_err);
    end
    set_op(0, 20, 4);
    bus.req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({bus.req_ready, bus.div_start} !== 5'b00000) begin
        n_err++; $display("FAIL to_blocked cyc%0d: got rdy=%b start=%b want 0000/0",
                          i, bus.req_ready, bus.div_start);
      end
    end
    hang = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL to_resume: got %b want 0001", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    n_cmp++;
    if (bus.rsp_q !== WIDTH'(5) || bus.rsp_r !== WIDTH'(0) || bus.rsp_err !== 1'b0) begin
      n_err++; $display("FAIL to_next: got q=%0d r=%0d err=%b want q=5 r=0 err=0",
                        bus.rsp_q, bus.rsp_r, bus.rsp_err);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] rdy; bit ok; int lat;
    hang = 1'b1;
    issue(2, 100, 7, rdy, ok);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.div_x, bus.div_y, bus.rsp_id, bus.div_start, bus.rsp_valid} !== '0) begin
      n_err++; $display("FAIL mid_reset: got x=%0d y=%0d id=%0d start=%b v=%b want all 0",
                        bus.div_x, bus.div_y, bus.rsp_id, bus.div_start, bus.rsp_valid);
    end
    set_op(0, 3, 9);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({bus.req_ready, bus.div_start} !== 5'b00000) begin
        n_err++; $display("FAIL mid_blocked cyc%0d: got rdy=%b start=%b want 0000/0",
                          i, bus.req_ready, bus.div_start);
      end
    end
    hang = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL mid_resume: got %b want 0001", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(lat);
    n_cmp++;
    if (lat != 3 || bus.rsp_q !== WIDTH'(0) || bus.rsp_r !== WIDTH'(3)) begin
      n_err++; $display("FAIL mid_next: got lat=%0d q=%0d r=%0d want lat=3 q=0 r=3",
                        lat, bus.rsp_q, bus.rsp_r);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_single();
    test_early_out();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
